// File: rtl/page_compression_arbiter_if.sv
// page_compression_arbiter_if
//   AXI4-Stream bundle of LANES parallel lanes, flattened with lane i at
//   slice i. A single-lane instance carries a host stream; an N_CH-lane
//   instance carries the engine lanes.
//   tdata  LANES*DATA_BITS    payload
//   tkeep  LANES*DATA_BITS/8  byte enables
//   tlast  LANES              end of page
//   tvalid LANES              source has a beat
//   tready LANES              sink accepts the beat
//   modport master drives the payload and tvalid; modport slave drives tready.
interface page_compression_arbiter_if #(
  parameter int unsigned DATA_BITS = 512,
  parameter int unsigned LANES     = 1
);
  logic [LANES*DATA_BITS-1:0]   tdata;
  logic [LANES*DATA_BITS/8-1:0] tkeep;
  logic [LANES-1:0]             tlast;
  logic [LANES-1:0]             tvalid;
  logic [LANES-1:0]             tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/page_compression_arbiter.sv
// page_compression_arbiter
//   Deals tlast-framed host pages round-robin across N_CH compression engine
//   lanes and re-emits the engine results on the host source in original
//   page order, using a FIFO of dispatched channel IDs.
// Ports:
//   aclk, areset   clock; synchronous active-high reset
//   s_axis         host page input (1 lane, slave)
//   eng_in         engine input lanes (N_CH lanes, master), payload broadcast
//   eng_out        engine result lanes (N_CH lanes, slave)
//   m_axis         host result output (1 lane, master)
//   pages_in/out   accepted / emitted page counters
// Build option:
//   PAGE_ARB_CNT_EN  defined: page counters present; otherwise tied to 0.
module page_compression_arbiter #(
  parameter int unsigned DATA_BITS   = 512,
  parameter int unsigned N_CH        = 4,
  parameter int unsigned ORDER_DEPTH = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  page_compression_arbiter_if.slave  s_axis,
  page_compression_arbiter_if.master eng_in,
  page_compression_arbiter_if.slave  eng_out,
  page_compression_arbiter_if.master m_axis,
  output logic [31:0]                pages_in,
  output logic [31:0]                pages_out
);
  localparam int unsigned KEEP_BITS = DATA_BITS / 8;
  localparam int unsigned PTR_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned ADDR_W    = $clog2(ORDER_DEPTH);
  localparam int unsigned CNT_W     = ADDR_W + 1;

  typedef enum logic {D_IDLE, D_STREAM} d_state_t;
  typedef enum logic {C_IDLE, C_STREAM} c_state_t;

  d_state_t             r_d_state, w_d_next;
  c_state_t             r_c_state, w_c_next;
  logic [PTR_W-1:0]     r_rr_ptr,  w_rr_next;
  logic [PTR_W-1:0]     r_cur_ch;

  logic [PTR_W-1:0]     r_fifo_mem [ORDER_DEPTH];
  logic [ADDR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 w_fifo_full, w_fifo_empty;
  logic                 w_push, w_pop;

  logic                 w_s_ready, w_s_fire;
  logic                 w_m_valid, w_m_last, w_m_fire;

  assign w_fifo_full  = (r_count == CNT_W'(ORDER_DEPTH));
  assign w_fifo_empty = (r_count == '0);

  // ---------------- dispatch ----------------
  // The FIFO only gates the first beat of a page; the rest of the page
  // follows the slot already reserved for it.
  assign w_s_ready = ~areset & eng_in.tready[r_rr_ptr] &
                     ((r_d_state == D_STREAM) | ~w_fifo_full);
  assign w_s_fire  = s_axis.tvalid[0] & w_s_ready;

  assign s_axis.tready = w_s_ready;
  assign eng_in.tdata  = {N_CH{s_axis.tdata}};
  assign eng_in.tkeep  = {N_CH{s_axis.tkeep}};
  assign eng_in.tlast  = {N_CH{s_axis.tlast}};

  always_comb begin
    eng_in.tvalid = '0;
    if (~areset && s_axis.tvalid[0] && ((r_d_state == D_STREAM) || ~w_fifo_full))
      eng_in.tvalid[r_rr_ptr] = 1'b1;
  end

  always_comb begin
    w_d_next  = r_d_state;
    w_rr_next = r_rr_ptr;
    w_push    = 1'b0;
    case (r_d_state)
      D_IDLE: begin
        if (w_s_fire) begin
          w_push = 1'b1;
          if (s_axis.tlast[0])
            w_rr_next = (r_rr_ptr == PTR_W'(N_CH - 1)) ? '0 : r_rr_ptr + 1'b1;
          else
            w_d_next = D_STREAM;
        end
      end
      D_STREAM: begin
        if (w_s_fire && s_axis.tlast[0]) begin
          w_rr_next = (r_rr_ptr == PTR_W'(N_CH - 1)) ? '0 : r_rr_ptr + 1'b1;
          w_d_next  = D_IDLE;
        end
      end
      default: w_d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_d_state <= D_IDLE;
      r_rr_ptr  <= '0;
    end else begin
      r_d_state <= w_d_next;
      r_rr_ptr  <= w_rr_next;
    end
  end

  // ---------------- order FIFO ----------------
  always_ff @(posedge aclk) begin
    if (w_push)
      r_fifo_mem[r_wr_ptr] <= r_rr_ptr;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------- collect ----------------
  assign w_m_valid = (r_c_state == C_STREAM) & ~areset & eng_out.tvalid[r_cur_ch];
  assign w_m_last  = (r_c_state == C_STREAM) & eng_out.tlast[r_cur_ch];
  assign w_m_fire  = w_m_valid & m_axis.tready[0];

  always_comb begin
    m_axis.tdata   = '0;
    m_axis.tkeep   = '0;
    m_axis.tlast   = w_m_last;
    m_axis.tvalid  = w_m_valid;
    eng_out.tready = '0;
    w_c_next       = r_c_state;
    w_pop          = 1'b0;
    case (r_c_state)
      C_IDLE: begin
        if (~w_fifo_empty && ~areset) begin
          w_pop    = 1'b1;
          w_c_next = C_STREAM;
        end
      end
      C_STREAM: begin
        m_axis.tdata = eng_out.tdata[r_cur_ch*DATA_BITS +: DATA_BITS];
        m_axis.tkeep = eng_out.tkeep[r_cur_ch*KEEP_BITS +: KEEP_BITS];
        eng_out.tready[r_cur_ch] = m_axis.tready[0] & ~areset;
        if (w_m_fire && w_m_last)
          w_c_next = C_IDLE;
      end
      default: w_c_next = C_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_c_state <= C_IDLE;
      r_cur_ch  <= '0;
    end else begin
      r_c_state <= w_c_next;
      if (w_pop)
        r_cur_ch <= r_fifo_mem[r_rd_ptr];
    end
  end

  // ---------------- page counters ----------------
`ifdef PAGE_ARB_CNT_EN
  logic [31:0] r_pages_in, r_pages_out;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pages_in  <= '0;
      r_pages_out <= '0;
    end else begin
      if (w_s_fire && s_axis.tlast[0]) r_pages_in  <= r_pages_in + 1'b1;
      if (w_m_fire && w_m_last)        r_pages_out <= r_pages_out + 1'b1;
    end
  end

  assign pages_in  = r_pages_in;
  assign pages_out = r_pages_out;
`else
  assign pages_in  = '0;
  assign pages_out = '0;
`endif
endmodule

// File: tb/tb_page_compression_arbiter.sv
`timescale 1ns/1ps
module tb_page_compression_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned NC = 4;
  localparam int unsigned OD = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] pages_in, pages_out;

  always #5 aclk = ~aclk;

  page_compression_arbiter_if #(.DATA_BITS(DW), .LANES(1))  s_axis ();
  page_compression_arbiter_if #(.DATA_BITS(DW), .LANES(NC)) eng_in ();
  page_compression_arbiter_if #(.DATA_BITS(DW), .LANES(NC)) eng_out ();
  page_compression_arbiter_if #(.DATA_BITS(DW), .LANES(1))  m_axis ();

  page_compression_arbiter #(.DATA_BITS(DW), .N_CH(NC), .ORDER_DEPTH(OD)) dut (
    .aclk(aclk), .areset(areset),
    .s_axis(s_axis), .eng_in(eng_in), .eng_out(eng_out), .m_axis(m_axis),
    .pages_in(pages_in), .pages_out(pages_out)
  );

  int          checks = 0;
  int          failures = 0;
  beat_t       sb[$];          // expected m_axis beats in order
  int unsigned lane_q[$];      // expected dispatch lane per page
  int unsigned exp_lane = 0;
  int unsigned exp_pin = 0;
  int unsigned exp_pout = 0;
  logic        m_rdy = 1'b1;
  logic [NC-1:0] eng_rdy = '1;
  int          lat [NC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int unsigned n);
`ifdef PAGE_ARB_CNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n) * 32'd0;
`endif
  endfunction

  function automatic beat_t mk(input int unsigned page, input int unsigned idx, input logic last);
    beat_t b;
    b.d = (32'(page) << 16) ^ 32'(idx) ^ 32'h5A00_0000;
    b.k = last ? 4'b0011 : 4'b1111;
    b.l = last;
    return b;
  endfunction

  // ---------------- engine lane models (pass-through with latency) -----------
  beat_t       eq   [NC][$];
  int          eq_t [NC][$];
  beat_t       in_b [NC];
  logic [NC-1:0] in_f = '0, out_f = '0;
  logic        rst_s = 1'b0;
  logic        disp_mid = 1'b0;
  int          cyc = 0;

  initial forever begin
    @(negedge aclk);
    cyc++;
    for (int i = 0; i < NC; i++) begin
      if (rst_s) begin
        eq[i].delete();
        eq_t[i].delete();
      end else begin
        if (out_f[i]) begin
          void'(eq[i].pop_front());
          void'(eq_t[i].pop_front());
        end
        if (in_f[i]) begin
          eq[i].push_back(in_b[i]);
          eq_t[i].push_back(cyc);
        end
      end
    end
    eng_in.tready = eng_rdy;
    for (int i = 0; i < NC; i++) begin
      if (eq[i].size() > 0 && cyc >= eq_t[i][0] + lat[i]) begin
        eng_out.tvalid[i]          = 1'b1;
        eng_out.tdata[i*DW +: DW]  = eq[i][0].d;
        eng_out.tkeep[i*KW +: KW]  = eq[i][0].k;
        eng_out.tlast[i]           = eq[i][0].l;
      end else begin
        eng_out.tvalid[i]          = 1'b0;
        eng_out.tdata[i*DW +: DW]  = '0;
        eng_out.tkeep[i*KW +: KW]  = '0;
        eng_out.tlast[i]           = 1'b0;
      end
    end
    #1;
    rst_s = areset;
    in_f  = eng_in.tvalid & eng_in.tready;
    out_f = eng_out.tvalid & eng_out.tready;
    for (int i = 0; i < NC; i++) begin
      in_b[i].d = eng_in.tdata[i*DW +: DW];
      in_b[i].k = eng_in.tkeep[i*KW +: KW];
      in_b[i].l = eng_in.tlast[i];
    end
    if (rst_s) disp_mid = 1'b0;
    else if (|in_f) begin
      chk("disp_onehot", 64'($countones(in_f)), 64'd1);
      if (!disp_mid) begin
        int unsigned got = 0;
        for (int i = 0; i < NC; i++) if (in_f[i]) got = i;
        if (lane_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL disp_lane actual=%0d required=none", got);
        end else
          chk("disp_lane", 64'(got), 64'(lane_q.pop_front()));
      end
      disp_mid = !s_axis.tlast[0];
    end
  end

  // ---------------- m_axis monitor ----------------
  logic was_last = 1'b0;
  initial forever begin
    @(negedge aclk);
    m_axis.tready = m_rdy;
    #1;
    if (areset) was_last = 1'b0;
    else begin
      if (was_last) chk("page_bubble", 64'(m_axis.tvalid), 64'd0);
      was_last = 1'b0;
      if (m_axis.tvalid[0] && m_axis.tready[0]) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL m_beat actual=%0h required=none", m_axis.tdata);
        end else begin
          beat_t e;
          e = sb.pop_front();
          chk("m_beat", 64'({m_axis.tdata, m_axis.tkeep, m_axis.tlast}), 64'(e));
        end
        was_last = m_axis.tlast[0];
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_beat(input beat_t b);
    bit ok = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = b.d;
    s_axis.tkeep  = b.k;
    s_axis.tlast  = b.l;
    for (int n = 0; n < 2000; n++) begin
      #1;
      if (s_axis.tready[0]) ok = 1;
      @(negedge aclk);
      if (ok) break;
    end
    s_axis.tvalid = 1'b0;
    if (!ok) begin
      checks++; failures++;
      $display("FAIL s_accept_timeout actual=0 required=1");
    end
  endtask

  task automatic send_page(input int unsigned pid, input int unsigned nb);
    for (int unsigned j = 0; j < nb; j++) sb.push_back(mk(pid, j, j == nb - 1));
    lane_q.push_back(exp_lane);
    exp_lane = (exp_lane + 1) % NC;
    exp_pin++;
    exp_pout++;
    for (int unsigned j = 0; j < nb; j++) drive_beat(mk(pid, j, j == nb - 1));
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 5000 && sb.size() != 0; n++) @(negedge aclk);
    repeat (4) @(negedge aclk);
    chk("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    for (int i = 0; i < NC; i++) lat[i] = 5;
    areset = 1'b1;
    s_axis.tvalid = 1'b1;      // held high so the reset gating is observable
    s_axis.tdata  = '0;
    s_axis.tkeep  = '0;
    s_axis.tlast  = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    chk("rst_s_tready",   64'(s_axis.tready),   64'd0);
    chk("rst_eng_tvalid", 64'(eng_in.tvalid),   64'd0);
    chk("rst_eng_tready", 64'(eng_out.tready),  64'd0);
    chk("rst_m_tvalid",   64'(m_axis.tvalid),   64'd0);
    chk("rst_m_tlast",    64'(m_axis.tlast),    64'd0);
    chk("rst_pages_in",   64'(pages_in),        64'd0);
    chk("rst_pages_out",  64'(pages_out),       64'd0);
    @(negedge aclk);
    s_axis.tvalid = 1'b0;
    areset = 1'b0;
    @(negedge aclk);

    // 8 pages of 64 beats, everything ready: lanes 0,1,2,3,0,1,2,3
    for (int unsigned p = 0; p < 8; p++) send_page(p, 64);
    wait_drain();
    chk("cnt_in_8",  64'(pages_in),  64'(cnt_exp(exp_pin)));
    chk("cnt_out_8", 64'(pages_out), 64'(cnt_exp(exp_pout)));

    // Lane 0 slow: later lanes must wait behind page 8
    lat[0] = 200;
    fork
      for (int unsigned p = 8; p < 12; p++) send_page(p, 4);
      begin
        repeat (60) @(negedge aclk);
        #1;
        chk("bp_eng_tready", 64'(eng_out.tready[3:1]), 64'd0);
        chk("bp_lane1_ready", 64'(eng_out.tvalid[1]),  64'd1);
        chk("bp_m_tvalid",   64'(m_axis.tvalid),       64'd0);
      end
    join
    wait_drain();
    lat[0] = 5;

    // Output stalled, single-beat pages: two fill the FIFO and one sits in
    // the collector, so the fourth must be held off.
    m_rdy = 1'b0;
    for (int unsigned p = 12; p < 15; p++) send_page(p, 1);
    sb.push_back(mk(15, 0, 1'b1));
    lane_q.push_back(exp_lane);
    exp_lane = (exp_lane + 1) % NC;
    exp_pin++;
    exp_pout++;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = mk(15, 0, 1'b1).d;
    s_axis.tkeep  = mk(15, 0, 1'b1).k;
    s_axis.tlast  = 1'b1;
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (s_axis.tready[0]) seen = 1;
      @(negedge aclk);
    end
    chk("full_hold", 64'(seen), 64'd0);
    m_rdy = 1'b1;
    drive_beat(mk(15, 0, 1'b1));
    wait_drain();
    chk("cnt_in_16", 64'(pages_in), 64'(cnt_exp(exp_pin)));

    // Reset while a page is in flight on lane 2
    send_page(16, 2);
    send_page(17, 2);
    wait_drain();
    m_rdy = 1'b0;
    lane_q.push_back(exp_lane);
    chk("abort_lane_is_2", 64'(exp_lane), 64'd2);
    for (int unsigned j = 0; j < 3; j++) drive_beat(mk(18, j, 1'b0));
    areset = 1'b1;
    @(negedge aclk);
    #1;
    chk("mid_rst_m_tvalid",  64'(m_axis.tvalid),  64'd0);
    chk("mid_rst_eng_tready",64'(eng_out.tready), 64'd0);
    chk("mid_rst_pages_in",  64'(pages_in),       64'd0);
    chk("mid_rst_pages_out", 64'(pages_out),      64'd0);
    @(negedge aclk);
    areset = 1'b0;
    m_rdy = 1'b1;
    exp_lane = 0;
    exp_pin = 0;
    exp_pout = 0;
    #1;
    chk("post_rst_s_tready", 64'(s_axis.tready), 64'd1);
    @(negedge aclk);
    send_page(19, 5);
    wait_drain();
    chk("cnt_in_post",  64'(pages_in),  64'(cnt_exp(exp_pin)));
    chk("cnt_out_post", 64'(pages_out), 64'(cnt_exp(exp_pout)));
    chk("lane_q_left",  64'(lane_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
